spi_master: RTL
===============

# spi_master

SPI bus master that drives SCK, MOSI and SS and captures MISO for one 8-bit full-duplex transfer per request, in all four SPI modes. It is the initiator counterpart to the existing SPI slave: the host logic loads a byte, pulses START, and receives the returned byte with a DONE strobe. All logic runs on the system clock PCLK. SCK is generated internally by a programmable divider.

## Interface
- HALF_DIV, default 4: SCK half-period in PCLK cycles (H). Legal range 2..255.
- PCLK  in  1  system clock; all state updates on its rising edge
- PRESETn  in  1  asynchronous active-low reset
- START  in  1  transfer request; sampled only when BUSY=0
- MODE  in  2  {CPOL, CPHA}; latched on START accept
- TX_DATA  in  8  byte to send MSB-first; latched on START accept
- MISO  in  1  serial data from slave
- SCK  out  1  serial clock
- MOSI  out  1  serial data to slave
- SS  out  1  slave select, active low
- RX_DATA  out  8  last received byte; updated only at DONE
- BUSY  out  1  high from START accept until the end of the HOLD gap
- DONE  out  1  one-cycle pulse when RX_DATA is valid

## Operation
- Reset (asynchronous, immediate, including mid-transfer): SS=1, SCK=0, MOSI=0, RX_DATA=8'h00, BUSY=0, DONE=0, FSM=IDLE, all counters 0.
- FSM states: IDLE -> XFER -> LAST -> HOLD -> IDLE.
  - IDLE: SCK is a registered copy of MODE[1], so the idle level settles before SS falls. On START=1, latch MODE and TX_DATA into the shift register, then go to XFER.
  - XFER: generate 16 SCK edges, one every H cycles. Odd-numbered edges are leading edges; even-numbered edges are trailing edges. After edge 16, go to LAST.
  - LAST: wait H cycles. Then raise SS, load the receive shifter into RX_DATA, pulse DONE, and go to HOLD.
  - HOLD: keep SS=1 and BUSY=1 for H cycles, then go to IDLE with BUSY=0.
- Edge behaviour in CPHA=0 (modes 00, 10):
  - MOSI = TX bit 7 in the same cycle SS falls.
  - Sample MISO on each leading edge.
  - Shift MOSI to the next bit on each trailing edge, except the 16th.
- Edge behaviour in CPHA=1 (modes 01, 11):
  - MOSI changes on each leading edge (bit 7 on edge 1).
  - Sample MISO on each trailing edge.
- MISO sampling: MISO is captured by the same PCLK edge that toggles SCK to the sampling level. The received bit shifts into the LSB, MSB first.
- START while BUSY=1 is ignored, with no queuing. Changes to MODE or TX_DATA during BUSY have no effect.
- After the final edge, SCK rests at CPOL. MOSI holds its last bit until the next transfer.

## Timing
- Let t0 be the PCLK edge at which START=1 is sampled in IDLE.
- From t0: SS=0, BUSY=1, SCK=CPOL.
- SCK edge k (k=1..16) is at t0+k·H. SCK has a 50 % duty cycle with period 2H.
- t0+17H: SS=1, DONE=1 for exactly one cycle, RX_DATA updated.
- t0+18H: BUSY=0. START is accepted from this edge, so the minimum request spacing is 18H cycles.
- Output registers: SCK, MOSI, SS, BUSY, DONE and RX_DATA are all driven straight from flops, with no combinational paths from inputs to outputs.

## Structure
- Shared package spi_pkg holds:
  - mode encodings SPI_MODE0..SPI_MODE3, plus CPOL bit index 1 and CPHA bit index 0
  - the FSM state encoding
  - the transfer width constant 8
- One sub-module, spi_clk_gen:
  - contains the half-period counter (loads HALF_DIV-1 and counts down)
  - outputs a one-cycle edge strobe and the toggling SCK level
  - enabled only in XFER
- Top level holds the FSM, the edge counter (0..16), the TX and RX shift registers and the RX_DATA register.

## Test plan
- Reset mid-transfer: assert PRESETn=0 at t0+5H -> SS=1, SCK=0, BUSY=0, RX_DATA=8'h00 in the same cycle. A new START after release behaves normally.
- Mode 0, H=4, TX_DATA=8'hA5, MISO looped to MOSI -> SCK rises at t0+4, 12, …, 60. DONE at t0+68 with RX_DATA=8'hA5. BUSY falls at t0+72.
- Back-to-back with SPI slave in modes 00, 01, 10, 11: master TX=8'h3C, slave DATA=8'hC3 -> master RX_DATA=8'hC3 and slave OUT=8'h3C in every mode. SCK idles at CPOL before SS falls.
- START held high continuously -> a new transfer begins exactly 18H cycles after the previous t0. Exactly one DONE pulse per transfer.
- START pulse at t0+10 during BUSY, with MODE/TX_DATA changed mid-transfer -> ignored. The current transfer completes with the originally latched values.
- Edge count check, MODE=11, TX=8'h00, MISO=1 -> exactly 16 SCK transitions while SS=0, MOSI held 0, RX_DATA=8'hFF.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: mode encodings, FSM states and
// transfer geometry.
package spi_pkg;

    localparam int XFER_WIDTH = 8;
    localparam int EDGE_COUNT = 2 * XFER_WIDTH;

    localparam int CPOL_BIT = 1;
    localparam int CPHA_BIT = 0;

    typedef enum logic [1:0] {
        SPI_MODE0 = 2'b00,
        SPI_MODE1 = 2'b01,
        SPI_MODE2 = 2'b10,
        SPI_MODE3 = 2'b11
    } spi_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_LAST,
        ST_HOLD
    } spi_state_e;

endpackage

// File: rtl/spi_clk_gen.sv
// SCK generator: half-period down-counter producing an edge strobe and the
// toggling SCK level; parks SCK at idle_level whenever disabled.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int HALF_DIV = 4
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic en,
    input  logic idle_level,
    output logic edge_stb,
    output logic sck
);

    localparam logic [7:0] RELOAD = 8'(HALF_DIV - 1);

    logic [7:0] cnt;

    // The strobe marks the PCLK edge on which SCK toggles.
    assign edge_stb = en && (cnt == 8'd0);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt <= 8'd0;
            sck <= 1'b0;
        end else if (!en) begin
            cnt <= RELOAD;
            sck <= idle_level;
        end else if (edge_stb) begin
            cnt <= RELOAD;
            sck <= ~sck;
        end else begin
            cnt <= cnt - 8'd1;
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI master: one 8-bit full-duplex transfer per START in any of the four
// SPI modes, SCK derived from PCLK by a programmable half-period divider.
module spi_master
    import spi_pkg::*;
#(
    parameter int HALF_DIV = 4
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       START,
    input  logic [1:0] MODE,
    input  logic [7:0] TX_DATA,
    input  logic       MISO,
    output logic       SCK,
    output logic       MOSI,
    output logic       SS,
    output logic [7:0] RX_DATA,
    output logic       BUSY,
    output logic       DONE
);

    localparam logic [7:0] RELOAD    = 8'(HALF_DIV - 1);
    localparam logic [4:0] LAST_EDGE = 5'(EDGE_COUNT - 1);

    spi_state_e            state;
    logic [4:0]            edge_cnt;
    logic [7:0]            wait_cnt;
    logic [XFER_WIDTH-1:0] tx_sh;
    logic [XFER_WIDTH-1:0] rx_sh;
    logic                  cpol_q;
    logic                  cpha_q;

    logic edge_stb;
    logic clk_en;
    logic accept;
    logic idle_level;
    logic leading;

    // A request is also taken on the final HOLD cycle, giving an 18H cadence.
    assign accept     = START && ((state == ST_IDLE) ||
                                  ((state == ST_HOLD) && (wait_cnt == 8'd0)));
    assign clk_en     = (state == ST_XFER);
    assign idle_level = ((state == ST_IDLE) || accept) ? MODE[CPOL_BIT] : cpol_q;
    assign leading    = ~edge_cnt[0];

    spi_clk_gen #(
        .HALF_DIV (HALF_DIV)
    ) u_clk_gen (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .en         (clk_en),
        .idle_level (idle_level),
        .edge_stb   (edge_stb),
        .sck        (SCK)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state    <= ST_IDLE;
            edge_cnt <= 5'd0;
            wait_cnt <= 8'd0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            SS       <= 1'b1;
            MOSI     <= 1'b0;
            RX_DATA  <= 8'h00;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
        end else begin
            DONE <= 1'b0;

            case (state)
                ST_XFER: begin
                    if (edge_stb) begin
                        edge_cnt <= edge_cnt + 5'd1;
                        if (leading != cpha_q) begin
                            rx_sh <= {rx_sh[XFER_WIDTH-2:0], MISO};
                        end else if (cpha_q || (edge_cnt != LAST_EDGE)) begin
                            MOSI  <= tx_sh[XFER_WIDTH-1];
                            tx_sh <= {tx_sh[XFER_WIDTH-2:0], 1'b0};
                        end
                        if (edge_cnt == LAST_EDGE) begin
                            state    <= ST_LAST;
                            wait_cnt <= RELOAD;
                        end
                    end
                end

                ST_LAST: begin
                    if (wait_cnt == 8'd0) begin
                        SS       <= 1'b1;
                        RX_DATA  <= rx_sh;
                        DONE     <= 1'b1;
                        state    <= ST_HOLD;
                        wait_cnt <= RELOAD;
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end

                ST_HOLD: begin
                    if (wait_cnt == 8'd0) begin
                        BUSY  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end

                default: ;
            endcase

            // Placed after the case so an accept on the last HOLD cycle
            // overrides the return to IDLE.
            if (accept) begin
                state    <= ST_XFER;
                SS       <= 1'b0;
                BUSY     <= 1'b1;
                cpol_q   <= MODE[CPOL_BIT];
                cpha_q   <= MODE[CPHA_BIT];
                edge_cnt <= 5'd0;
                rx_sh    <= '0;
                if (!MODE[CPHA_BIT]) begin
                    MOSI  <= TX_DATA[XFER_WIDTH-1];
                    tx_sh <= {TX_DATA[XFER_WIDTH-2:0], 1'b0};
                end else begin
                    tx_sh <= TX_DATA;
                end
            end
        end
    end

endmodule
